matmul_sequencer: RTL
=====================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the operand element width.
REQ-002 SHALL have parameter ACC_W, default 20, meaning the accumulator and result width.
REQ-003 SHALL have parameter ADDR_W, default 8, meaning the operand and result memory address width.
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  request to start one multiplication.
REQ-007 SHALL have port matrix_size  in  4  N, sampled only on an accepted start.
REQ-008 SHALL have port abort  in  1  synchronous cancel of a run in progress.
REQ-009 SHALL have port busy  out  1  high from the cycle after accept until DONE.
REQ-010 SHALL have port done  out  1  one-cycle pulse when every C element has been written.
REQ-011 SHALL have port err  out  1  one-cycle pulse when a start arrives with N=0.
REQ-012 SHALL have ports rd_en  out  1, a_addr  out  ADDR_W, b_addr  out  ADDR_W: operand read request and addresses.
REQ-013 SHALL have ports a_data  in  DATA_W, b_data  in  DATA_W: operand data, valid exactly 1 cycle after rd_en.
REQ-014 SHALL have ports c_we  out  1, c_addr  out  ADDR_W, c_data  out  ACC_W: result write strobe, address and data.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, WRITE, DONE.
REQ-016 IDLE: start=1 and N!=0 -> latch N, clear i, j and k to 0, go to RUN; start=1 and N=0 -> err=1 for one cycle and stay in IDLE.
REQ-017 RUN: rd_en=1 every cycle, a_addr=i*N+k, b_addr=k*N+j, k stepping 0..N-1; after issuing k=N-1 -> DRAIN.
REQ-018 Addresses SHALL be generated with incrementing counters: a_addr +1 per k, b_addr +N per k. No multipliers.
REQ-019 MAC: acc <= a_data*b_data on the data cycle of k=0; acc <= acc + a_data*b_data on each later data cycle. Unsigned arithmetic; product 2*DATA_W bits, zero-extended to ACC_W.
REQ-020 DRAIN: rd_en=0; accumulate the final product -> WRITE.
REQ-021 WRITE: c_we=1, c_addr=i*N+j, c_data=acc for exactly one cycle. If (i,j)=(N-1,N-1) -> DONE. Otherwise: j+1, with wrap j=N-1 -> j=0, i+1; reset k; -> RUN.
REQ-022 DONE: done=1 and busy=0 this cycle -> IDLE.
REQ-023 Latency: accept in cycle 0, first rd_en in cycle 1, done in cycle N*N*(N+2)+1.
REQ-024 start SHALL be ignored while busy; matrix_size changes are ignored while busy.
REQ-025 abort=1 in RUN, DRAIN or WRITE -> IDLE next cycle. No c_we, no done; busy and rd_en drop the same next cycle.
REQ-026 abort and start in the same IDLE cycle: start wins; abort has no effect in IDLE or DONE.
REQ-027 Result width: N=15 with all operands 255 (975375) SHALL fit ACC_W=20 without overflow.
REQ-028 rd_en, c_we, done and err SHALL never be asserted in the same cycle.

Reset
REQ-029 rst low -> state IDLE; busy, done, err, rd_en, c_we = 0; all addresses, c_data, acc, i, j, k and latched N = 0.
REQ-030 Reset mid-run SHALL abandon the run with no further c_we; the next start behaves as from power-up.

Structure
REQ-031 Shared package matmul_pkg SHALL hold the state enum encoding and the constants MAX_N=15, DATA_W, ACC_W and ADDR_W.
REQ-032 SHALL instantiate one sub-module mac_unit for multiply/accumulate (inputs clear_en, acc_en), while address counters and FSM stay in matmul_sequencer.

Verification
REQ-033 Scenario: N=2, A=[1 2;3 4], B=[5 6;7 8] -> c_we at addr 0,1,2,3 with data 19,22,43,50; done in cycle 17.
REQ-034 Scenario: N=1, A=7, B=9 -> single write c_addr=0, c_data=63; done in cycle 4.
REQ-035 Scenario: N=15, all operands 255 -> 225 writes at addr 0..224, each 975375; done in cycle 3826.
REQ-036 Scenario: start with N=0 -> err for 1 cycle; busy, rd_en and c_we stay 0.
REQ-037 Scenario: N=3 run, abort after the 2nd c_we -> IDLE next cycle, no more writes, no done; a following N=2 run reproduces REQ-033.
REQ-038 Scenario: rst low mid-run, plus start pulses while busy -> all outputs 0 during reset, extra starts ignored, and the next run is correct.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer: FSM state encoding
// and default sizing constants.
package matmul_pkg;
   localparam int MAX_N  = 15;  // largest supported matrix dimension
   localparam int N_W    = 4;   // width of the matrix_size field
   localparam int DATA_W = 8;   // operand element width
   localparam int ACC_W  = 20;  // accumulator / result width (15*255*255 fits)
   localparam int ADDR_W = 8;   // operand / result memory address width

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;
endpackage

// File: rtl/matmul_sequencer_mac_unit.sv
// Unsigned multiply-accumulate for one C element.
// Ports: clk, rst (async active-low), clear_en (load product, first term),
//        acc_en (add product), a_data/b_data (operands), acc (running sum).
module mac_unit #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_en,
   input  logic              acc_en,
   input  logic [DATA_W-1:0] a_data,
   input  logic [DATA_W-1:0] b_data,
   output logic [ACC_W-1:0]  acc
);
   logic [2*DATA_W-1:0] prod;
   logic [ACC_W-1:0]    prod_ext;

   assign prod     = a_data * b_data;
   assign prod_ext = ACC_W'(prod);

   // clear_en starts a fresh sum, so it takes priority over acc_en
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          acc <= '0;
      else if (clear_en) acc <= prod_ext;
      else if (acc_en)   acc <= acc + prod_ext;
   end
endmodule

// File: rtl/matmul_sequencer.sv
// Sequencer for C = A x B on NxN unsigned matrices held in external memories.
// Walks i, j, k with incrementing address counters, feeds a mac_unit and
// writes each C element once.
// Ports: clk, rst (async active-low), start/matrix_size/abort (control in),
//        busy/done/err (status out), rd_en/a_addr/b_addr + a_data/b_data
//        (operand read, data one cycle after rd_en), c_we/c_addr/c_data (result).
module matmul_sequencer #(
   parameter int DATA_W = matmul_pkg::DATA_W,
   parameter int ACC_W  = matmul_pkg::ACC_W,
   parameter int ADDR_W = matmul_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        matrix_size,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              rd_en,
   output logic [ADDR_W-1:0] a_addr,
   output logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic [DATA_W-1:0] b_data,
   output logic              c_we,
   output logic [ADDR_W-1:0] c_addr,
   output logic [ACC_W-1:0]  c_data
);
   import matmul_pkg::*;

   state_t            state;
   logic [3:0]        n_lat, i, j, k;
   logic [ADDR_W-1:0] row_base;   // i*N, base of the current A row
   logic [ADDR_W-1:0] n_ext;
   logic              last_k, last_i, last_j;
   logic              dvld, dfirst;

   assign n_ext  = ADDR_W'(n_lat);
   assign last_k = (k == n_lat - 4'd1);
   assign last_i = (i == n_lat - 4'd1);
   assign last_j = (j == n_lat - 4'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         n_lat    <= '0;
         i        <= '0;
         j        <= '0;
         k        <= '0;
         row_base <= '0;
         a_addr   <= '0;
         b_addr   <= '0;
         c_addr   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         rd_en    <= 1'b0;
         c_we     <= 1'b0;
      end else begin
         // single-cycle strobes
         done <= 1'b0;
         err  <= 1'b0;
         c_we <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (matrix_size != 4'd0) begin
                     n_lat    <= matrix_size;
                     i        <= '0;
                     j        <= '0;
                     k        <= '0;
                     row_base <= '0;
                     a_addr   <= '0;
                     b_addr   <= '0;
                     c_addr   <= '0;
                     busy     <= 1'b1;
                     rd_en    <= 1'b1;
                     state    <= RUN;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  busy  <= 1'b0;
                  rd_en <= 1'b0;
                  state <= IDLE;
               end else if (last_k) begin
                  rd_en <= 1'b0;
                  state <= DRAIN;
               end else begin
                  k      <= k + 4'd1;
                  a_addr <= a_addr + ADDR_W'(1);
                  b_addr <= b_addr + n_ext;
               end
            end
            DRAIN: begin
               // last product lands in the accumulator at the end of this cycle
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  c_we  <= 1'b1;
                  state <= WRITE;
               end
            end
            WRITE: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (last_i && last_j) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  // C is row-major and visited in order, so c_addr just counts
                  c_addr <= c_addr + ADDR_W'(1);
                  k      <= '0;
                  rd_en  <= 1'b1;
                  state  <= RUN;
                  if (last_j) begin
                     j        <= '0;
                     i        <= i + 4'd1;
                     row_base <= row_base + n_ext;
                     a_addr   <= row_base + n_ext;
                     b_addr   <= '0;
                  end else begin
                     j      <= j + 4'd1;
                     a_addr <= row_base;
                     b_addr <= ADDR_W'(j) + ADDR_W'(1);
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Operand data trails rd_en by one cycle; track which cycle carries k=0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dvld   <= 1'b0;
         dfirst <= 1'b0;
      end else begin
         dvld   <= rd_en & ~abort;
         dfirst <= (k == 4'd0);
      end
   end

   mac_unit #(
      .DATA_W(DATA_W),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .clear_en(dvld & dfirst),
      .acc_en  (dvld & ~dfirst),
      .a_data  (a_data),
      .b_data  (b_data),
      .acc     (c_data)
   );
endmodule
